// File: rtl/accum_bank.sv
`default_nettype none
// ============================================================================
//  Module   : accum_bank
//  Purpose  : Multi-channel signed accumulator. CH lanes share one input beat
//             stream: each lane is preloaded with a per-channel bias on
//             start, adds one beat per accepted handshake, and after the
//             beat flagged in_last the lane results are drained one channel
//             at a time over a valid/ready port.
//  Build    : ACCUM_SAT_EN defined   -> lanes saturate on overflow and set
//                                       the sticky per-lane ovf flag.
//             ACCUM_SAT_EN undefined -> lanes wrap modulo 2^DATA_W, ovf = 0.
//  Ports    : clk, rst              clock, synchronous active-high reset
//             start                 begin burst (IDLE only), loads bias_in
//             bias_in[CH*DATA_W]    per-lane bias, lane k at [k*DATA_W +: DATA_W]
//             in_valid/in_ready     input beat handshake (ready only in ACC)
//             in_data[CH*DATA_W]    one addend per lane, packed like bias_in
//             in_last               final beat of the burst
//             out_valid/out_ready   drain handshake (valid only in DRAIN)
//             out_data/out_ch       lane value and its channel index
//             out_last              high while channel CH-1 is presented
//             busy                  any state other than IDLE
//             ovf[CH]               sticky per-lane overflow (saturating build)
//  Revision : 1.0  initial release
// ============================================================================
module accum_bank #(
  parameter int DATA_W = 16,
  parameter int CH     = 4,
  parameter int CH_W   = $clog2(CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CH*DATA_W-1:0] bias_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_last,
  output logic                 busy,
  output logic [CH-1:0]        ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CH_W-1:0] C_LAST_IDX = CH_W'(CH - 1);

  state_t            r_state;
  logic [CH_W-1:0]   r_idx;

  logic              w_load;
  logic              w_beat;
  logic [DATA_W-1:0] w_lane [CH];

  // start is only honoured in IDLE; beats are only accepted in ACC.
  assign w_load = (r_state == S_IDLE) && start;
  assign w_beat = (r_state == S_ACC) && in_valid;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (in_valid && in_last) begin
            r_state <= S_DRAIN;
            r_idx   <= '0;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_idx == C_LAST_IDX) begin
              r_state <= S_IDLE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Lanes
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < CH; k++) begin : g_lane
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_add;
    logic [DATA_W-1:0] w_res;

    assign w_add = in_data[k*DATA_W +: DATA_W];

`ifdef ACCUM_SAT_EN
    logic [DATA_W:0] w_sum;
    logic            w_of;
    logic            r_ovf;

    // Sign-extended add: the two top bits disagree exactly on overflow, and
    // the extra top bit carries the true sign of the sum.
    assign w_sum = {r_acc[DATA_W-1], r_acc} + {w_add[DATA_W-1], w_add};
    assign w_of  = w_sum[DATA_W] ^ w_sum[DATA_W-1];
    assign w_res = !w_of        ? w_sum[DATA_W-1:0] :
                   w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                   {1'b0, {(DATA_W-1){1'b1}}};

    always_ff @(posedge clk) begin
      if (rst) begin
        r_ovf <= 1'b0;
      end else if (w_load) begin
        r_ovf <= 1'b0;
      end else if (w_beat && w_of) begin
        r_ovf <= 1'b1;
      end
    end

    assign ovf[k] = r_ovf;
`else
    assign w_res  = r_acc + w_add;
    assign ovf[k] = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        r_acc <= '0;
      end else if (w_load) begin
        r_acc <= bias_in[k*DATA_W +: DATA_W];
      end else if (w_beat) begin
        r_acc <= w_res;
      end
    end

    assign w_lane[k] = r_acc;
  end : g_lane

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state/index only)
  // --------------------------------------------------------------------------
  assign in_ready  = (r_state == S_ACC);
  assign out_valid = (r_state == S_DRAIN);
  assign busy      = (r_state != S_IDLE);
  assign out_ch    = r_idx;
  assign out_last  = (r_state == S_DRAIN) && (r_idx == C_LAST_IDX);
  assign out_data  = (r_state == S_DRAIN) ? w_lane[r_idx] : '0;

endmodule : accum_bank
`default_nettype wire

// File: tb/tb_accum_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accum_bank
//  Purpose  : Directed self-checking bench for accum_bank (DATA_W=16, CH=4).
//             A behavioural lane model produces the expected drain sequence,
//             which is queued when the final beat is driven and compared as
//             the DUT presents each channel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_accum_bank;

  localparam int DW   = 16;
  localparam int CH   = 4;
  localparam int CH_W = 2;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [DW-1:0]   data;
    logic            last;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [CH*DW-1:0]    bias_in = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [CH*DW-1:0]    in_data = '0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DW-1:0]       out_data;
  logic [CH_W-1:0]     out_ch;
  logic                out_last;
  logic                busy;
  logic [CH-1:0]       ovf;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mlane [CH];
  logic [CH-1:0] mvf;
  exp_t          exp_q [$];

  accum_bank #(.DATA_W(DW), .CH(CH)) dut (
    .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*DW-1:0] pack4(input logic [DW-1:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [CH-1:0] exp_ovf();
`ifdef ACCUM_SAT_EN
    return mvf;
`else
    return '0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < CH; k++) mlane[k] = '0;
    mvf = '0;
    exp_q.delete();
  endtask

  task automatic start_burst(input logic [CH*DW-1:0] b);
    bias_in = b;
    start   = 1'b1;
    step();
    start   = 1'b0;
    bias_in = '0;
    for (int k = 0; k < CH; k++) mlane[k] = b[k*DW +: DW];
    mvf = '0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_ready", 32'(in_ready), 32'd1);
  endtask

  // gap cycles drive in_last with junk data but no valid: must be ignored.
  task automatic send_beat(input logic [CH*DW-1:0] d, input bit last, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = {$urandom, $urandom};
      step();
    end
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    for (int k = 0; k < CH; k++) begin
      int s;
      s = int'($signed(mlane[k])) + int'($signed(d[k*DW +: DW]));
`ifdef ACCUM_SAT_EN
      if (s > 32767) begin
        mlane[k] = 16'h7FFF;
        mvf[k]   = 1'b1;
      end else if (s < -32768) begin
        mlane[k] = 16'h8000;
        mvf[k]   = 1'b1;
      end else begin
        mlane[k] = s[DW-1:0];
      end
`else
      mlane[k] = s[DW-1:0];
`endif
    end
    if (last) begin
      for (int k = 0; k < CH; k++)
        exp_q.push_back('{ch: CH_W'(k), data: mlane[k], last: (k == CH - 1)});
    end
  endtask

  // Drain up to n queued results; optionally stall one channel and/or pulse
  // start together with the final handshake.
  task automatic drain(input int n, input int stall_ch, input int stall_n, input bit start_on_last);
    exp_t e;
    int   done = 0;
    while (exp_q.size() > 0 && done < n) begin
      int w = 0;
      while (!out_valid && w < 20) begin
        step();
        w++;
      end
      chk("drain_valid", 32'(out_valid), 32'd1);
      if (!out_valid) begin
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      chk("drain_ch", 32'(out_ch), 32'(e.ch));
      chk("drain_data", 32'(out_data), 32'(e.data));
      chk("drain_last", 32'(out_last), 32'(e.last));
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_ovf", 32'(ovf), 32'(exp_ovf()));
      if (int'(e.ch) == stall_ch) begin
        for (int s = 0; s < stall_n; s++) begin
          out_ready = 1'b0;
          step();
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_ch", 32'(out_ch), 32'(e.ch));
          chk("stall_data", 32'(out_data), 32'(e.data));
        end
      end
      out_ready = 1'b1;
      if (e.last && start_on_last) begin
        start   = 1'b1;
        bias_in = {4{16'h1234}};
      end
      step();
      out_ready = 1'b0;
      start     = 1'b0;
      bias_in   = '0;
      done++;
      if (e.last) begin
        chk("post_drain_valid", 32'(out_valid), 32'd0);
        chk("post_drain_busy", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // ---------------- in_valid/in_last while IDLE are ignored
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = pack4(16'd9, 16'd9, 16'd9, 16'd9);
    step();
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    chk("idle_in_busy", 32'(busy), 32'd0);
    chk("idle_in_out_valid", 32'(out_valid), 32'd0);

    // ---------------- basic: bias {4,3,2,1}, three beats of +1
    start_burst(pack4(16'd4, 16'd3, 16'd2, 16'd1));
    send_beat({4{16'h0001}}, 1'b0, 0);
    send_beat({4{16'h0001}}, 1'b0, 0);
    chk("acc_no_out_valid", 32'(out_valid), 32'd0);
    send_beat({4{16'h0001}}, 1'b1, 0);
    chk("last_out_valid", 32'(out_valid), 32'd1);
    chk("last_lane0", 32'(out_data), 32'd4);
    drain(CH, -1, 0, 1'b0);

    // ---------------- backpressure: beat gaps, ch1 stalled 3 cycles
    start_burst(pack4(16'd4, 16'd3, 16'd2, 16'd1));
    send_beat({4{16'h0001}}, 1'b0, 2);
    send_beat({4{16'h0001}}, 1'b0, 1);
    send_beat({4{16'h0001}}, 1'b1, 3);
    drain(CH, 1, 3, 1'b0);

    // ---------------- overflow / wrap
    start_burst(pack4(16'hFFFF, 16'h0100, 16'h8005, 16'h7FF0));
    send_beat(pack4(16'h0001, 16'h0005, 16'hFFF0, 16'h0020), 1'b1, 0);
`ifdef ACCUM_SAT_EN
    chk("sat_lane0", 32'(out_data), 32'h7FFF);
`else
    chk("wrap_lane0", 32'(out_data), 32'h8010);
`endif
    drain(CH, -1, 0, 1'b0);

    // ---------------- start during ACC and during final handshake ignored
    start_burst(pack4(16'd100, 16'd200, 16'd300, 16'd400));
    send_beat(pack4(16'd1, 16'd2, 16'd3, 16'd4), 1'b0, 0);
    start   = 1'b1;
    bias_in = {4{16'h5555}};
    step();
    start   = 1'b0;
    bias_in = '0;
    chk("acc_start_busy", 32'(busy), 32'd1);
    send_beat(pack4(16'hFFFF, 16'hFFFE, 16'd7, 16'd8), 1'b1, 0);
    drain(CH, -1, 0, 1'b1);
    step();
    chk("late_start_busy", 32'(busy), 32'd0);

    // ---------------- single-beat burst
    start_burst('0);
    send_beat(pack4(16'd40, 16'd30, 16'd20, 16'd10), 1'b1, 0);
    chk("single_lane0", 32'(out_data), 32'd10);
    drain(CH, -1, 0, 1'b0);

    // ---------------- random burst
    start_burst({$urandom, $urandom});
    for (int b = 0; b < 5; b++)
      send_beat({$urandom, $urandom}, (b == 4), $urandom_range(0, 2));
    drain(CH, 2, 1, 1'b0);

    // ---------------- reset while draining ch2
    start_burst(pack4(16'd1, 16'd2, 16'd3, 16'd4));
    send_beat(pack4(16'd5, 16'd5, 16'd5, 16'd5), 1'b1, 0);
    drain(2, -1, 0, 1'b0);
    chk("pre_rst_ch", 32'(out_ch), 32'd2);
    do_reset();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_ch", 32'(out_ch), 32'd0);

    // ---------------- recovery after reset
    start_burst(pack4(16'd0, 16'd0, 16'd0, 16'd7));
    send_beat(pack4(16'd1, 16'd1, 16'd1, 16'd1), 1'b1, 0);
    drain(CH, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_accum_bank
`default_nettype wire
